pass_check_param: RTL and testbench

- Parametrised successor to the fixed five-character password FSM.
- Password length and content are programmable at run time through a load interface. Character width and maximum length are set by parameters.
- Checks a stream of characters strobed by enable and reports a one-cycle pass or fail verdict after exactly prog_len characters.
- Sits between the keypad/UART character source and the unlock logic.

---
 rtl/pass_check_pkg.sv | 26 ++
 rtl/pass_store.sv | 28 ++
 rtl/pass_check_param.sv | 188 ++++++++++++++++++
 tb/tb_pass_check_param.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/pass_check_pkg.sv
// Shared types and default sizing for the programmable password checker.
// Default widths below match the default parameter set of pass_check_param.
package pass_check_pkg;

    localparam int DEF_CHAR_W      = 8;
    localparam int DEF_MAX_LEN     = 8;
    localparam int DEF_MAX_TRIES   = 3;
    localparam int DEF_LOCK_CYCLES = 16;

    // Address width for an n-entry array, never narrower than one bit.
    function automatic int addr_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int DEF_IDX_W = addr_bits(DEF_MAX_LEN);
    localparam int DEF_LEN_W = $clog2(DEF_MAX_LEN + 1);
    localparam int DEF_CNT_W = $clog2(DEF_MAX_TRIES + 1);

    typedef enum logic [1:0] {
        UNPROG = 2'd0,
        PROG   = 2'd1,
        ENTRY  = 2'd2,
        LOCKED = 2'd3
    } state_t;

endpackage

// File: rtl/pass_store.sv
// Password character store: MAX_LEN x CHAR_W registers, one synchronous write
// port and one combinational read port. The array is intentionally not reset.
module pass_store
    import pass_check_pkg::*;
#(
    parameter int CHAR_W  = DEF_CHAR_W,
    parameter int MAX_LEN = DEF_MAX_LEN,
    parameter int AW      = addr_bits(MAX_LEN)
) (
    input  logic              clock,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [CHAR_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [CHAR_W-1:0] rdata
);

    logic [CHAR_W-1:0] mem [MAX_LEN];

    always_ff @(posedge clock) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/pass_check_param.sv
// Programmable password checker with run-time length/content loading.
// Optional consecutive-failure lockout is built when PASS_LOCKOUT_EN is defined.
//
// state  | meaning
// UNPROG | no password stored, characters ignored
// PROG   | receiving password characters into the store
// ENTRY  | comparing entered characters against the stored password
// LOCKED | too many consecutive failures, characters ignored until timeout
module pass_check_param
    import pass_check_pkg::*;
#(
    parameter int CHAR_W      = DEF_CHAR_W,
    parameter int MAX_LEN     = DEF_MAX_LEN,
    parameter int MAX_TRIES   = DEF_MAX_TRIES,
    parameter int LOCK_CYCLES = DEF_LOCK_CYCLES
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         enable,
    input  logic [CHAR_W-1:0]            data_in,
    input  logic                         prog_start,
    input  logic [$clog2(MAX_LEN+1)-1:0] prog_len,
    input  logic                         prog_valid,
    input  logic [CHAR_W-1:0]            prog_data,
    output logic                         prog_err,
    output logic                         programmed,
    output logic                         pass_ok,
    output logic                         pass_fail,
    output logic                         locked
);

    localparam int IDX_W = addr_bits(MAX_LEN);
    localparam int LEN_W = $clog2(MAX_LEN + 1);

    if (MAX_LEN < 1 || MAX_TRIES < 1 || LOCK_CYCLES < 1) begin : g_bad_cfg
        $error("pass_check_param: MAX_LEN, MAX_TRIES and LOCK_CYCLES must be >= 1");
    end

    state_t            state;
    logic [LEN_W-1:0]  len;
    logic [IDX_W-1:0]  idx;
    logic              mismatch;
    logic [CHAR_W-1:0] rdata;
    logic              len_ok;
    logic              last;
    logic              miss;
    logic              we;

`ifdef PASS_LOCKOUT_EN
    localparam int CNT_W = $clog2(MAX_TRIES + 1);
    localparam int TMR_W = $clog2(LOCK_CYCLES + 1);
    logic [CNT_W-1:0] fail_cnt;
    logic [TMR_W-1:0] timer;
`else
    assign locked = 1'b0;
`endif

    assign len_ok = (prog_len != '0) && (prog_len <= LEN_W'(MAX_LEN));
    assign last   = (LEN_W'(idx) == len - LEN_W'(1));
    assign miss   = (data_in != rdata);
    // prog_start takes priority over a coincident programming character
    assign we     = (state == PROG) && prog_valid && !prog_start;

    pass_store #(
        .CHAR_W  (CHAR_W),
        .MAX_LEN (MAX_LEN),
        .AW      (IDX_W)
    ) u_store (
        .clock (clock),
        .we    (we),
        .waddr (idx),
        .wdata (prog_data),
        .raddr (idx),
        .rdata (rdata)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= UNPROG;
            len        <= '0;
            idx        <= '0;
            mismatch   <= 1'b0;
            programmed <= 1'b0;
            prog_err   <= 1'b0;
            pass_ok    <= 1'b0;
            pass_fail  <= 1'b0;
`ifdef PASS_LOCKOUT_EN
            fail_cnt   <= '0;
            timer      <= '0;
            locked     <= 1'b0;
`endif
        end else begin
            prog_err  <= 1'b0;
            pass_ok   <= 1'b0;
            pass_fail <= 1'b0;
            case (state)
                UNPROG, PROG: begin
                    if (prog_start) begin
                        if (len_ok) begin
                            len   <= prog_len;
                            idx   <= '0;
                            state <= PROG;
                        end else begin
                            prog_err <= 1'b1;
                        end
                    end else if (state == PROG && prog_valid) begin
                        if (last) begin
                            programmed <= 1'b1;
                            idx        <= '0;
                            state      <= ENTRY;
`ifdef PASS_LOCKOUT_EN
                            fail_cnt   <= '0;
`endif
                        end else begin
                            idx <= idx + IDX_W'(1);
                        end
                    end
                end
                ENTRY: begin
                    if (prog_start) begin
                        // abort the attempt silently; an invalid length keeps the old password
                        idx      <= '0;
                        mismatch <= 1'b0;
                        if (len_ok) begin
                            len        <= prog_len;
                            programmed <= 1'b0;
                            state      <= PROG;
                        end else begin
                            prog_err <= 1'b1;
                        end
                    end else if (enable) begin
                        if (last) begin
                            idx      <= '0;
                            mismatch <= 1'b0;
                            if (mismatch || miss) begin
                                pass_fail <= 1'b1;
`ifdef PASS_LOCKOUT_EN
                                if (fail_cnt == CNT_W'(MAX_TRIES - 1)) begin
                                    fail_cnt <= CNT_W'(MAX_TRIES);
                                    timer    <= TMR_W'(LOCK_CYCLES);
                                    locked   <= 1'b1;
                                    state    <= LOCKED;
                                end else begin
                                    fail_cnt <= fail_cnt + CNT_W'(1);
                                end
`endif
                            end else begin
                                pass_ok <= 1'b1;
`ifdef PASS_LOCKOUT_EN
                                fail_cnt <= '0;
`endif
                            end
                        end else begin
                            idx      <= idx + IDX_W'(1);
                            mismatch <= mismatch | miss;
                        end
                    end
                end
`ifdef PASS_LOCKOUT_EN
                LOCKED: begin
                    if (prog_start && len_ok) begin
                        len        <= prog_len;
                        idx        <= '0;
                        mismatch   <= 1'b0;
                        programmed <= 1'b0;
                        locked     <= 1'b0;
                        fail_cnt   <= '0;
                        state      <= PROG;
                    end else begin
                        // an invalid reprogram request does not pause the lockout
                        prog_err <= prog_start;
                        if (timer == TMR_W'(1)) begin
                            locked   <= 1'b0;
                            fail_cnt <= '0;
                            idx      <= '0;
                            state    <= ENTRY;
                        end else begin
                            timer <= timer - TMR_W'(1);
                        end
                    end
                end
`endif
                default: state <= UNPROG;
            endcase
        end
    end

endmodule

// File: tb/tb_pass_check_param.sv
// Bench for pass_check_param: directed scenarios plus randomized traffic, all
// checked every cycle against a queue-based model of the password rules.
module tb_pass_check_param;

    localparam int CHAR_W      = 8;
    localparam int MAX_LEN     = 8;
    localparam int MAX_TRIES   = 3;
    localparam int LOCK_CYCLES = 16;
    localparam int LEN_W       = $clog2(MAX_LEN + 1);

    logic              clock = 1'b0;
    logic              reset;
    logic              enable;
    logic [CHAR_W-1:0] data_in;
    logic              prog_start;
    logic [LEN_W-1:0]  prog_len;
    logic              prog_valid;
    logic [CHAR_W-1:0] prog_data;
    logic              prog_err, programmed, pass_ok, pass_fail, locked;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_on = 0;

    pass_check_param #(
        .CHAR_W(CHAR_W), .MAX_LEN(MAX_LEN), .MAX_TRIES(MAX_TRIES), .LOCK_CYCLES(LOCK_CYCLES)
    ) dut (
        .clock(clock), .reset(reset), .enable(enable), .data_in(data_in),
        .prog_start(prog_start), .prog_len(prog_len), .prog_valid(prog_valid),
        .prog_data(prog_data), .prog_err(prog_err), .programmed(programmed),
        .pass_ok(pass_ok), .pass_fail(pass_fail), .locked(locked)
    );

    always #5 clock = ~clock;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual %0h required %0h at %0t", nm, act, exp, $time);
        end
    endfunction

    // Reference model: password as an array, attempts and programming as queues.
    logic [CHAR_W-1:0] m_pw [MAX_LEN];
    logic [CHAR_W-1:0] m_new [$];
    logic [CHAR_W-1:0] m_try [$];
    int m_len = 0, m_target = 0, m_lock = 0, m_fails = 0;
    bit m_prog_active = 0, m_programmed = 0;
    bit e_ok = 0, e_fail = 0, e_err = 0;

    function automatic void model_reset();
        m_new.delete(); m_try.delete();
        m_len = 0; m_target = 0; m_lock = 0; m_fails = 0;
        m_prog_active = 0; m_programmed = 0;
        e_ok = 0; e_fail = 0; e_err = 0;
    endfunction

    function automatic void tick_lock();
        m_lock--;
        if (m_lock == 0) m_fails = 0;
    endfunction

    function automatic void model_step();
        bit valid, match;
        e_ok = 0; e_fail = 0; e_err = 0;
        valid = (prog_len >= 1) && (int'(prog_len) <= MAX_LEN);
        if (prog_start && valid) begin
            if (m_lock > 0) m_fails = 0;
            m_prog_active = 1; m_target = int'(prog_len);
            m_new.delete(); m_try.delete();
            m_programmed = 0; m_lock = 0;
        end else if (prog_start) begin
            e_err = 1;
            if (m_lock > 0) tick_lock();
            else if (!m_prog_active) m_try.delete();
        end else if (m_prog_active) begin
            if (prog_valid) begin
                m_new.push_back(prog_data);
                if (m_new.size() == m_target) begin
                    for (int i = 0; i < m_target; i++) m_pw[i] = m_new[i];
                    m_len = m_target; m_programmed = 1; m_prog_active = 0; m_fails = 0;
                end
            end
        end else if (m_lock > 0) begin
            tick_lock();
        end else if (m_programmed && enable) begin
            m_try.push_back(data_in);
            if (m_try.size() == m_len) begin
                match = 1;
                for (int i = 0; i < m_len; i++) if (m_try[i] !== m_pw[i]) match = 0;
                m_try.delete();
                if (match) begin
                    e_ok = 1; m_fails = 0;
                end else begin
                    e_fail = 1; m_fails++;
`ifdef PASS_LOCKOUT_EN
                    if (m_fails == MAX_TRIES) m_lock = LOCK_CYCLES;
`endif
                end
            end
        end
    endfunction

    always @(posedge clock or posedge reset) begin
        if (reset) model_reset();
        else model_step();
    end

    always @(negedge clock) begin
        if (chk_on) begin
            chk("pass_ok", pass_ok, e_ok);
            chk("pass_fail", pass_fail, e_fail);
            chk("prog_err", prog_err, e_err);
            chk("programmed", programmed, m_programmed);
            chk("locked", locked, m_lock > 0);
        end
    end

    task automatic step(input bit en, input logic [7:0] d, input bit ps, input int pl,
                        input bit pv, input logic [7:0] pd);
        enable = en; data_in = d; prog_start = ps; prog_len = LEN_W'(pl);
        prog_valid = pv; prog_data = pd;
        @(negedge clock);
    endtask

    task automatic idle();            step(0, 0, 0, 0, 0, 0); endtask
    task automatic enter(input logic [7:0] c); step(1, c, 0, 0, 0, 0); endtask
    task automatic prog_go(input int l);       step(0, 0, 1, l, 0, 0); endtask
    task automatic prog_ch(input logic [7:0] c); step(0, 0, 0, 0, 1, c); endtask

    task automatic enter_str(input string s);
        for (int i = 0; i < s.len(); i++) enter(s[i]);
    endtask

    task automatic prog_str(input string s);
        prog_go(s.len());
        for (int i = 0; i < s.len(); i++) prog_ch(s[i]);
    endtask

    function automatic logic [7:0] pick();
        return 8'h41 + 8'($urandom_range(0, 1));
    endfunction

    initial begin
        int pl;
        reset = 1'b1;
        chk_on = 1;
        idle();
        chk("rst_programmed", programmed, 0);
        chk("rst_verdict", {pass_ok, pass_fail}, 0);
        chk("rst_err_lock", {prog_err, locked}, 0);
        idle();
        reset = 1'b0;

        prog_str("TAULE");
        chk("prog_done", programmed, 1);
        enter_str("TAUL");
        chk("no_early_verdict", {pass_ok, pass_fail}, 0);
        enter("E");
        chk("taule_ok", pass_ok, 1);
        chk("taule_nofail", pass_fail, 0);
        idle();
        chk("ok_one_cycle", pass_ok, 0);

        enter_str("TXULE");
        chk("txule_fail", pass_fail, 1);
        enter_str("TAULE");
        chk("b2b_ok", pass_ok, 1);

        prog_go(0);
        chk("err_len0", prog_err, 1);
        chk("len0_kept", programmed, 1);
        prog_go(MAX_LEN + 1);
        chk("err_len_big", prog_err, 1);
        chk("big_kept", programmed, 1);
        enter_str("TAULE");
        chk("old_pw_intact", pass_ok, 1);

        enter_str("TA");
        prog_go(3);
        chk("abort_no_verdict", {pass_ok, pass_fail}, 0);
        chk("abort_unprog", programmed, 0);
        prog_ch("A"); prog_ch("B");
        chk("partial_unprog", programmed, 0);
        prog_ch("C");
        chk("abc_programmed", programmed, 1);
        enter_str("ABC");
        chk("abc_ok", pass_ok, 1);

        for (int t = 0; t < MAX_TRIES; t++) enter_str("ABD");
        chk("third_fail", pass_fail, 1);
`ifdef PASS_LOCKOUT_EN
        chk("locked_set", locked, 1);
        enter_str("ABC");
        chk("lock_ignores", pass_ok, 0);
`else
        chk("never_locked", locked, 0);
        enter_str("ABC");
        chk("no_lock_ok", pass_ok, 1);
`endif
        for (int k = 0; k < LOCK_CYCLES + 4 && locked; k++) idle();
        chk("lock_release", locked, 0);
        enter_str("ABC");
        chk("after_lock_ok", pass_ok, 1);

        enter("A");
        #2 reset = 1'b1;
        #1;
        chk("async_rst_prog", programmed, 0);
        chk("async_rst_out", {pass_ok, pass_fail, prog_err, locked}, 0);
        @(negedge clock);
        reset = 1'b0;
        enter_str("ABC");
        chk("unprog_ignored", pass_ok, 0);

        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 999) < 2) begin
                #3 reset = 1'b1;
                #1 chk("rnd_rst_prog", programmed, 0);
                @(negedge clock);
                reset = 1'b0;
            end else begin
                pl = ($urandom_range(0, 3) == 0) ? $urandom_range(0, MAX_LEN + 1) : $urandom_range(1, 3);
                step($urandom_range(0, 9) < 6, pick(), $urandom_range(0, 39) == 0, pl,
                     $urandom_range(0, 1) == 1, pick());
            end
        end

        idle();
        chk_on = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
